// File: rtl/sc_maxtrack_pkg.sv
// sc_maxtrack shared types: FSM state encoding and default sizes.
// Optional index tracking is enabled by defining SC_MAXTRACK_INDEX_EN.
package sc_maxtrack_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FIRST = 3'd1,
      S_RUN   = 3'd2,
      S_CMP   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam int unsigned DEF_DATAWIDTH = 8;
   localparam int unsigned DEF_WINDOW    = 16;

   function automatic int unsigned idx_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sc_maxtrack_if.sv
// sc_maxtrack bus: sample handshake, comparator operands/result, status.
// The index signal exists only when SC_MAXTRACK_INDEX_EN is defined.
interface sc_maxtrack_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned IW = 4
) ();

   logic          SC_MAXTRACK_start_In;
   logic [DW-1:0] SC_MAXTRACK_data_InBUS;
   logic          SC_MAXTRACK_valid_In;
   logic          SC_MAXTRACK_ready_Out;
   logic [DW-1:0] SC_MAXTRACK_cmpA_OutBUS;
   logic [DW-1:0] SC_MAXTRACK_cmpB_OutBUS;
   logic          SC_MAXTRACK_greaterthan_In;
   logic [DW-1:0] SC_MAXTRACK_max_OutBUS;
`ifdef SC_MAXTRACK_INDEX_EN
   logic [IW-1:0] SC_MAXTRACK_index_OutBUS;
`endif
   logic          SC_MAXTRACK_busy_Out;
   logic          SC_MAXTRACK_done_Out;

   modport slave (
      input  SC_MAXTRACK_start_In,
      input  SC_MAXTRACK_data_InBUS,
      input  SC_MAXTRACK_valid_In,
      input  SC_MAXTRACK_greaterthan_In,
      output SC_MAXTRACK_ready_Out,
      output SC_MAXTRACK_cmpA_OutBUS,
      output SC_MAXTRACK_cmpB_OutBUS,
      output SC_MAXTRACK_max_OutBUS,
`ifdef SC_MAXTRACK_INDEX_EN
      output SC_MAXTRACK_index_OutBUS,
`endif
      output SC_MAXTRACK_busy_Out,
      output SC_MAXTRACK_done_Out
   );

   modport master (
      output SC_MAXTRACK_start_In,
      output SC_MAXTRACK_data_InBUS,
      output SC_MAXTRACK_valid_In,
      output SC_MAXTRACK_greaterthan_In,
      input  SC_MAXTRACK_ready_Out,
      input  SC_MAXTRACK_cmpA_OutBUS,
      input  SC_MAXTRACK_cmpB_OutBUS,
      input  SC_MAXTRACK_max_OutBUS,
`ifdef SC_MAXTRACK_INDEX_EN
      input  SC_MAXTRACK_index_OutBUS,
`endif
      input  SC_MAXTRACK_busy_Out,
      input  SC_MAXTRACK_done_Out
   );

endinterface

// File: rtl/sc_maxtrack_counter.sv
// Window sample counter with clear, increment and terminal-count flag.
// idx_o is present only when SC_MAXTRACK_INDEX_EN is defined.
module sc_maxtrack_counter #(
   parameter int unsigned WINDOW = 16,
   parameter int unsigned IW     = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          inc_i,
`ifdef SC_MAXTRACK_INDEX_EN
   output logic [IW-1:0] idx_o,
`endif
   output logic          last_o
);

   localparam int unsigned CW = IW + 1;
   localparam logic [CW-1:0] WIN = CW'(WINDOW);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // last_o: the sample being consumed now is the final one of the window
   assign last_o = (cnt_q + 1'b1) == WIN;

`ifdef SC_MAXTRACK_INDEX_EN
   assign idx_o = cnt_q[IW-1:0];
`endif

endmodule

// File: rtl/sc_maxtrack.sv
// Running-maximum tracker driving an external A>B comparator.
// Define SC_MAXTRACK_INDEX_EN to add the index register and port.
module sc_maxtrack
   import sc_maxtrack_pkg::*;
#(
   parameter int unsigned NUMBER_DATAWIDTH  = DEF_DATAWIDTH,
   parameter int unsigned NUMBER_WINDOW     = DEF_WINDOW,
   parameter int unsigned NUMBER_INDEXWIDTH = idx_width(NUMBER_WINDOW)
) (
   input logic         SC_MAXTRACK_CLOCK_50,
   input logic         SC_MAXTRACK_RESET_InHigh,
   sc_maxtrack_if.slave bus
);

   localparam int unsigned DW = NUMBER_DATAWIDTH;
   localparam int unsigned IW = NUMBER_INDEXWIDTH;

   state_e        state_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic [DW-1:0] cmpa_q;
   logic [DW-1:0] max_q;
`ifdef SC_MAXTRACK_INDEX_EN
   logic [IW-1:0] idx_q;
   logic [IW-1:0] cnt_idx;
`endif

   logic xfer;
   logic cnt_clr;
   logic cnt_inc;
   logic cnt_last;

   assign xfer    = bus.SC_MAXTRACK_valid_In & ready_q;
   assign cnt_clr = (state_q == S_IDLE) & bus.SC_MAXTRACK_start_In;
   assign cnt_inc = ((state_q == S_FIRST) & xfer) | (state_q == S_CMP);

   sc_maxtrack_counter #(
      .WINDOW (NUMBER_WINDOW),
      .IW     (IW)
   ) u_cnt (
      .clk_i  (SC_MAXTRACK_CLOCK_50),
      .rst_i  (SC_MAXTRACK_RESET_InHigh),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
`ifdef SC_MAXTRACK_INDEX_EN
      .idx_o  (cnt_idx),
`endif
      .last_o (cnt_last)
   );

   always_ff @(posedge SC_MAXTRACK_CLOCK_50) begin
      if (SC_MAXTRACK_RESET_InHigh) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cmpa_q  <= '0;
         max_q   <= '0;
`ifdef SC_MAXTRACK_INDEX_EN
         idx_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.SC_MAXTRACK_start_In) begin
                  state_q <= S_FIRST;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_FIRST: begin
               if (xfer) begin
                  max_q <= bus.SC_MAXTRACK_data_InBUS;
`ifdef SC_MAXTRACK_INDEX_EN
                  idx_q <= '0;
`endif
                  // counter still 0 here, so last means a 1-sample window
                  if (cnt_last) begin
                     state_q <= S_DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (xfer) begin
                  cmpa_q  <= bus.SC_MAXTRACK_data_InBUS;
                  state_q <= S_CMP;
                  ready_q <= 1'b0;
               end
            end
            S_CMP: begin
               if (bus.SC_MAXTRACK_greaterthan_In) begin
                  max_q <= cmpa_q;
`ifdef SC_MAXTRACK_INDEX_EN
                  idx_q <= cnt_idx;
`endif
               end
               if (cnt_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.SC_MAXTRACK_ready_Out   = ready_q;
   assign bus.SC_MAXTRACK_busy_Out    = busy_q;
   assign bus.SC_MAXTRACK_done_Out    = done_q;
   assign bus.SC_MAXTRACK_cmpA_OutBUS = cmpa_q;
   assign bus.SC_MAXTRACK_cmpB_OutBUS = max_q;
   assign bus.SC_MAXTRACK_max_OutBUS  = max_q;
`ifdef SC_MAXTRACK_INDEX_EN
   assign bus.SC_MAXTRACK_index_OutBUS = idx_q;
`endif

endmodule

// File: tb/tb_sc_maxtrack.sv
// Self-checking bench for sc_maxtrack (window of 4, 8-bit samples).
// Index checks are compiled in when SC_MAXTRACK_INDEX_EN is defined.
module tb_sc_maxtrack;

   localparam int unsigned DW = 8;
   localparam int unsigned W  = 4;
   localparam int unsigned IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sc_maxtrack_if #(.DW(DW), .IW(IW)) bus ();

   sc_maxtrack #(
      .NUMBER_DATAWIDTH  (DW),
      .NUMBER_WINDOW     (W),
      .NUMBER_INDEXWIDTH (IW)
   ) dut (
      .SC_MAXTRACK_CLOCK_50     (clk),
      .SC_MAXTRACK_RESET_InHigh (rst),
      .bus                      (bus)
   );

   always #10 clk = ~clk;

   // external comparator
   assign bus.SC_MAXTRACK_greaterthan_In =
      bus.SC_MAXTRACK_cmpA_OutBUS > bus.SC_MAXTRACK_cmpB_OutBUS;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int dones  = 0;
   int xfers  = 0;
   int t0     = 0;
   bit after_run_xfer = 0;
   bit gt_in_cmp      = 0;
   logic prev_done    = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      after_run_xfer = 0;
      if (!rst && bus.SC_MAXTRACK_valid_In && bus.SC_MAXTRACK_ready_Out) begin
         xfers = xfers + 1;
         after_run_xfer = (xfers >= 2);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmpB_eq_max", bus.SC_MAXTRACK_cmpB_OutBUS,
             bus.SC_MAXTRACK_max_OutBUS);
         if (!bus.SC_MAXTRACK_busy_Out)
            chk("ready_low_idle", bus.SC_MAXTRACK_ready_Out, 0);
         if (after_run_xfer)
            chk("ready_low_cmp", bus.SC_MAXTRACK_ready_Out, 0);
         if (bus.SC_MAXTRACK_busy_Out && !bus.SC_MAXTRACK_ready_Out &&
             !bus.SC_MAXTRACK_done_Out && bus.SC_MAXTRACK_greaterthan_In)
            gt_in_cmp = 1;
         if (bus.SC_MAXTRACK_done_Out) begin
            dones++;
            chk("done_one_cycle", prev_done, 0);
         end
      end
      prev_done = bus.SC_MAXTRACK_done_Out;
   end

   function automatic void ref_max(input logic [DW-1:0] s [W],
                                   output int m, output int ix);
      m  = -1;
      ix = 0;
      for (int i = 0; i < W; i++)
         if (int'(s[i]) > m) begin
            m  = int'(s[i]);
            ix = i;
         end
   endfunction

   task automatic start_win();
      @(negedge clk);
      bus.SC_MAXTRACK_start_In = 1'b1;
      xfers = 0;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.SC_MAXTRACK_start_In = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] s, input int gap);
      int g;
      repeat (gap) begin
         @(negedge clk);
         bus.SC_MAXTRACK_valid_In = 1'b0;
      end
      @(negedge clk);
      bus.SC_MAXTRACK_valid_In   = 1'b1;
      bus.SC_MAXTRACK_data_InBUS = s;
      g = 0;
      while (!bus.SC_MAXTRACK_ready_Out && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk("send_timeout", 1, 0);
      @(posedge clk);
   endtask

   task automatic wait_done(input bit start_in_done, output int lat);
      int g;
      g = 0;
      lat = -1;
      while (g < 100) begin
         @(negedge clk);
         bus.SC_MAXTRACK_valid_In = 1'b0;
         if (bus.SC_MAXTRACK_done_Out) break;
         g++;
      end
      chk("done_seen", bus.SC_MAXTRACK_done_Out, 1);
      lat = cyc - t0;
      if (start_in_done) begin
         bus.SC_MAXTRACK_start_In = 1'b1;
         @(posedge clk);
         #1;
         bus.SC_MAXTRACK_start_In = 1'b0;
      end
   endtask

   task automatic run_window(input string tag, input logic [DW-1:0] s [W],
                             input int maxgap, input bit chk_time);
      int m, ix, lat, d0;
      ref_max(s, m, ix);
      d0 = dones;
      start_win();
      for (int i = 0; i < W; i++)
         send(s[i], (i == 0 || maxgap == 0) ? 0 : $urandom_range(0, maxgap));
      wait_done(1'b0, lat);
      chk({tag, "_max"}, bus.SC_MAXTRACK_max_OutBUS, m);
`ifdef SC_MAXTRACK_INDEX_EN
      chk({tag, "_idx"}, bus.SC_MAXTRACK_index_OutBUS, ix);
`endif
      if (chk_time) chk({tag, "_latency"}, lat, 1 + 2 * (W - 1));
      chk({tag, "_xfers"}, xfers, W);
      repeat (3) @(negedge clk);
      chk({tag, "_dones"}, dones - d0, 1);
      chk({tag, "_idle"}, bus.SC_MAXTRACK_busy_Out, 0);
      chk({tag, "_hold"}, bus.SC_MAXTRACK_max_OutBUS, m);
   endtask

   logic [DW-1:0] smp [W];
   int lat, d0;

   initial begin
      bus.SC_MAXTRACK_start_In   = 1'b0;
      bus.SC_MAXTRACK_valid_In   = 1'b0;
      bus.SC_MAXTRACK_data_InBUS = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.SC_MAXTRACK_ready_Out, 0);
      chk("rst_busy",  bus.SC_MAXTRACK_busy_Out, 0);
      chk("rst_done",  bus.SC_MAXTRACK_done_Out, 0);
      chk("rst_cmpA",  bus.SC_MAXTRACK_cmpA_OutBUS, 0);
      chk("rst_max",   bus.SC_MAXTRACK_max_OutBUS, 0);
`ifdef SC_MAXTRACK_INDEX_EN
      chk("rst_idx",   bus.SC_MAXTRACK_index_OutBUS, 0);
`endif
      rst = 1'b0;

      smp = '{8'd3, 8'd9, 8'd9, 8'd2};
      run_window("ties", smp, 0, 1'b1);

      gt_in_cmp = 0;
      smp = '{8'd255, 8'd10, 8'd0, 8'd7};
      run_window("desc", smp, 0, 1'b1);
      chk("desc_no_gt", gt_in_cmp, 0);

      smp = '{8'd1, 8'd2, 8'd3, 8'd4};
      run_window("gaps", smp, 5, 1'b0);

      // start pulsed in RUN and in the DONE cycle
      d0 = dones;
      start_win();
      send(8'd7, 0);
      @(negedge clk);
      bus.SC_MAXTRACK_valid_In = 1'b0;
      bus.SC_MAXTRACK_start_In = 1'b1;
      @(negedge clk);
      bus.SC_MAXTRACK_start_In = 1'b0;
      send(8'd20, 0);
      send(8'd5, 1);
      send(8'd20, 0);
      wait_done(1'b1, lat);
      chk("busy_start_max", bus.SC_MAXTRACK_max_OutBUS, 20);
`ifdef SC_MAXTRACK_INDEX_EN
      chk("busy_start_idx", bus.SC_MAXTRACK_index_OutBUS, 1);
`endif
      repeat (6) @(negedge clk);
      chk("busy_start_idle", bus.SC_MAXTRACK_busy_Out, 0);
      chk("busy_start_dones", dones - d0, 1);

      // reset while in CMP
      start_win();
      send(8'd10, 0);
      send(8'd50, 0);
      #1;
      rst = 1'b1;
      bus.SC_MAXTRACK_valid_In = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", bus.SC_MAXTRACK_ready_Out, 0);
      chk("mid_rst_busy",  bus.SC_MAXTRACK_busy_Out, 0);
      chk("mid_rst_done",  bus.SC_MAXTRACK_done_Out, 0);
      chk("mid_rst_cmpA",  bus.SC_MAXTRACK_cmpA_OutBUS, 0);
      chk("mid_rst_max",   bus.SC_MAXTRACK_max_OutBUS, 0);
`ifdef SC_MAXTRACK_INDEX_EN
      chk("mid_rst_idx",   bus.SC_MAXTRACK_index_OutBUS, 0);
`endif
      rst = 1'b0;
      smp = '{8'd5, 8'd6, 8'd1, 8'd0};
      run_window("post_rst", smp, 0, 1'b1);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < W; i++)
            smp[i] = (r < 3) ? DW'($urandom_range(0, 7))
                             : DW'($urandom_range(0, 255));
         run_window("rand", smp, 3, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
